// File: rtl/input_buffer_pkg.sv
// Shared flit-format constants, flit type codes and input-buffer FSM states.
package input_buffer_pkg;

  localparam int FLIT_SIZE    = 32;
  localparam int HEADER_LEN   = 2;
  localparam int VC_CLASS_POS = FLIT_SIZE - HEADER_LEN - 1;

  typedef logic [HEADER_LEN-1:0] flit_type_t;

  localparam flit_type_t SINGLE_FLIT = 2'b00;
  localparam flit_type_t HEAD_FLIT   = 2'b01;
  localparam flit_type_t BODY_FLIT   = 2'b10;
  localparam flit_type_t TAIL_FLIT   = 2'b11;

  typedef enum logic {
    IB_IDLE   = 1'b0,
    IB_LOCKED = 1'b1
  } ib_state_t;

  // Only HEAD and SINGLE flits may legally start a packet.
  function automatic logic isStartType(input flit_type_t t);
    return (t == HEAD_FLIT) || (t == SINGLE_FLIT);
  endfunction

endpackage

// File: rtl/input_buffer_flit_fifo.sv
// Single-clock flit FIFO; full/empty come from the occupancy counter so the
// pointers can wrap freely. A write while full is taken if a read pops too.
module flit_fifo #(
  parameter int DEPTH     = 8,
  parameter int FLIT_SIZE = 32,
  localparam int CNT_W    = $clog2(DEPTH + 1),
  localparam int PTR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [FLIT_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  output logic [FLIT_SIZE-1:0] rd_data,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty
);

  logic [FLIT_SIZE-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wrPtr;
  logic [PTR_W-1:0]     r_rdPtr;
  logic [CNT_W-1:0]     r_count;
  logic                 w_rdOk;
  logic                 w_wrOk;

  assign empty   = (r_count == '0);
  assign full    = (r_count == CNT_W'(DEPTH));
  assign w_rdOk  = rd_en && !empty;
  assign w_wrOk  = wr_en && (!full || w_rdOk);
  assign rd_data = r_mem[r_rdPtr];
  assign count   = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_wrOk) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_rdOk) r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_wrOk, w_rdOk})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wrOk) r_mem[r_wrPtr] <= wr_data;
  end

endmodule

// File: rtl/input_buffer.sv
// Per-port input buffer: two VC-class FIFOs, wormhole packet arbitration
// towards route computation, and one credit per dequeued flit.
module input_buffer
  import input_buffer_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int FLIT_SIZE = input_buffer_pkg::FLIT_SIZE,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] flit_in,
  input  logic                 flit_in_valid,
  input  logic                 stall,
  output logic [FLIT_SIZE-1:0] flit_out,
  output logic                 flit_valid_out,
  output logic [1:0]           credit_out,
  output logic [CNT_W-1:0]     occ0,
  output logic [CNT_W-1:0]     occ1,
  output logic                 overflow_err
);

  logic [FLIT_SIZE-1:0] w_head  [2];
  logic [CNT_W-1:0]     w_count [2];
  flit_type_t           w_type  [2];
  logic [1:0]           w_empty, w_full, w_start, w_junk;
  logic [1:0]           w_wrReq, w_wrEn, w_rdEn, w_discard;
  logic                 w_sel, w_valid, w_deq, w_ovf;
  logic                 w_selNext, w_rrNext;
  ib_state_t            w_stateNext;

  ib_state_t            r_state;
  logic                 r_sel, r_rr, r_overflow;
  logic [1:0]           r_credit;

  for (genvar v = 0; v < 2; v++) begin : g_fifo
    flit_fifo #(.DEPTH(DEPTH), .FLIT_SIZE(FLIT_SIZE)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (w_wrEn[v]),
      .wr_data (flit_in),
      .rd_en   (w_rdEn[v]),
      .rd_data (w_head[v]),
      .count   (w_count[v]),
      .full    (w_full[v]),
      .empty   (w_empty[v])
    );
  end

  always_comb begin
    for (int v = 0; v < 2; v++) begin
      w_type[v]  = w_head[v][FLIT_SIZE-1 -: HEADER_LEN];
      w_start[v] = !w_empty[v] && isStartType(w_type[v]);
      w_junk[v]  = !w_empty[v] && !isStartType(w_type[v]);
    end
  end

  // Stray BODY/TAIL heads seen while idle are popped (with credit) but never presented.
  always_comb begin
    w_sel       = r_sel;
    w_valid     = 1'b0;
    w_discard   = 2'b00;
    w_stateNext = r_state;
    w_selNext   = r_sel;
    w_rrNext    = r_rr;
    case (r_state)
      IB_IDLE: begin
        w_discard = w_junk;
        if (w_start[r_rr]) begin
          w_sel   = r_rr;
          w_valid = 1'b1;
        end else if (w_start[~r_rr]) begin
          w_sel   = ~r_rr;
          w_valid = 1'b1;
        end
      end
      IB_LOCKED: w_valid = !w_empty[r_sel];
      default:   w_stateNext = IB_IDLE;
    endcase
    w_deq = w_valid && !stall;
    if (w_deq) begin
      if (r_state == IB_IDLE) begin
        w_selNext = w_sel;
        w_rrNext  = ~w_sel;
        if (w_type[w_sel] == HEAD_FLIT) w_stateNext = IB_LOCKED;
      end else if (w_type[w_sel] == TAIL_FLIT) begin
        w_stateNext = IB_IDLE;
      end
    end
  end

  assign w_rdEn[0]  = w_discard[0] | (w_deq && !w_sel);
  assign w_rdEn[1]  = w_discard[1] | (w_deq && w_sel);
  assign w_wrReq[0] = flit_in_valid && !flit_in[VC_CLASS_POS];
  assign w_wrReq[1] = flit_in_valid && flit_in[VC_CLASS_POS];
  assign w_wrEn     = w_wrReq & (~w_full | w_rdEn);
  assign w_ovf      = |(w_wrReq & w_full & ~w_rdEn);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IB_IDLE;
      r_sel   <= 1'b0;
      r_rr    <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_sel   <= w_selNext;
      r_rr    <= w_rrNext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit   <= 2'b00;
      r_overflow <= 1'b0;
    end else begin
      r_credit <= w_rdEn;
      if (w_ovf) r_overflow <= 1'b1;
    end
  end

  assign flit_out       = w_head[w_sel];
  assign flit_valid_out = w_valid;
  assign credit_out     = r_credit;
  assign occ0           = w_count[0];
  assign occ1           = w_count[1];
  assign overflow_err   = r_overflow;

endmodule

// File: tb/tb_input_buffer.sv
// Directed bench for input_buffer (DEPTH=4): delivery latency, credits,
// wormhole locking, overflow, full-FIFO pass-through and reset flush.
module tb_input_buffer;
  import input_buffer_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] flit_in;
  logic        flit_in_valid;
  logic        stall;
  logic [31:0] flit_out;
  logic        flit_valid_out;
  logic [1:0]  credit_out;
  logic [2:0]  occ0;
  logic [2:0]  occ1;
  logic        overflow_err;

  int cmpCount  = 0;
  int failCount = 0;

  input_buffer #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .flit_in        (flit_in),
    .flit_in_valid  (flit_in_valid),
    .stall          (stall),
    .flit_out       (flit_out),
    .flit_valid_out (flit_valid_out),
    .credit_out     (credit_out),
    .occ0           (occ0),
    .occ1           (occ1),
    .overflow_err   (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mkFlit(input flit_type_t t, input logic vc, input logic [7:0] pay);
    return {t, vc, 21'd0, pay};
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] f, input logic s);
    flit_in_valid = v;
    flit_in       = f;
    stall         = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmpCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    applyStimulus(1'b0, '0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset valid", flit_valid_out, 0);
    checkOutput("reset credit", credit_out, 0);
    checkOutput("reset occ0", occ0, 0);
    checkOutput("reset occ1", occ1, 0);
    checkOutput("reset overflow", overflow_err, 0);

    // SINGLE on VC0: visible next cycle, credit the cycle after
    applyStimulus(1'b1, mkFlit(SINGLE_FLIT, 1'b0, 8'h01), 1'b0);
    checkOutput("t1 no bypass", flit_valid_out, 0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("t1 valid", flit_valid_out, 1);
    checkOutput("t1 flit", flit_out, mkFlit(SINGLE_FLIT, 1'b0, 8'h01));
    checkOutput("t1 occ0", occ0, 1);
    checkOutput("t1 credit early", credit_out, 0);
    tick();
    checkOutput("t1 credit", credit_out, 2'b01);
    checkOutput("t1 occ0 drained", occ0, 0);
    checkOutput("t1 valid after", flit_valid_out, 0);
    tick();

    // VC1 packet with VC0 HEAD arriving mid-packet: no interleaving
    applyStimulus(1'b1, mkFlit(HEAD_FLIT, 1'b1, 8'h11), 1'b0);
    tick();
    applyStimulus(1'b1, mkFlit(HEAD_FLIT, 1'b0, 8'h20), 1'b0);
    checkOutput("t2 H1 valid", flit_valid_out, 1);
    checkOutput("t2 H1 flit", flit_out, mkFlit(HEAD_FLIT, 1'b1, 8'h11));
    tick();
    applyStimulus(1'b1, mkFlit(BODY_FLIT, 1'b1, 8'h12), 1'b0);
    checkOutput("t2 locked wait", flit_valid_out, 0);
    checkOutput("t2 credit H1", credit_out, 2'b10);
    tick();
    applyStimulus(1'b1, mkFlit(TAIL_FLIT, 1'b1, 8'h13), 1'b0);
    checkOutput("t2 B1 flit", flit_out, mkFlit(BODY_FLIT, 1'b1, 8'h12));
    checkOutput("t2 B1 valid", flit_valid_out, 1);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("t2 T1 flit", flit_out, mkFlit(TAIL_FLIT, 1'b1, 8'h13));
    checkOutput("t2 credit B1", credit_out, 2'b10);
    tick();
    checkOutput("t2 H0 flit", flit_out, mkFlit(HEAD_FLIT, 1'b0, 8'h20));
    checkOutput("t2 H0 valid", flit_valid_out, 1);
    checkOutput("t2 credit T1", credit_out, 2'b10);
    tick();
    checkOutput("t2 credit H0", credit_out, 2'b01);
    checkOutput("t2 VC0 locked empty", flit_valid_out, 0);
    applyStimulus(1'b1, mkFlit(TAIL_FLIT, 1'b0, 8'h21), 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("t2 T0 flit", flit_out, mkFlit(TAIL_FLIT, 1'b0, 8'h21));
    tick();
    checkOutput("t2 credit T0", credit_out, 2'b01);
    checkOutput("t2 occ0 end", occ0, 0);
    checkOutput("t2 occ1 end", occ1, 0);

    // Five writes to VC0 under stall: fifth dropped, sticky overflow
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, mkFlit((i == 0) ? HEAD_FLIT : BODY_FLIT, 1'b0, 8'(8'h31 + i)), 1'b1);
      if (i == 4) begin
        checkOutput("t3 occ0 full", occ0, 4);
        checkOutput("t3 no overflow yet", overflow_err, 0);
      end
      tick();
    end
    checkOutput("t3 occ0 after drop", occ0, 4);
    checkOutput("t3 overflow", overflow_err, 1);
    checkOutput("t3 credit", credit_out, 0);
    checkOutput("t3 valid", flit_valid_out, 1);
    checkOutput("t3 flit", flit_out, mkFlit(HEAD_FLIT, 1'b0, 8'h31));
    applyStimulus(1'b0, '0, 1'b1);
    tick();
    checkOutput("t3 stable under stall", flit_out, mkFlit(HEAD_FLIT, 1'b0, 8'h31));
    checkOutput("t3 overflow sticky", overflow_err, 1);

    applyStimulus(1'b0, '0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst2 occ0", occ0, 0);
    checkOutput("rst2 overflow", overflow_err, 0);
    checkOutput("rst2 credit", credit_out, 0);
    checkOutput("rst2 valid", flit_valid_out, 0);

    // Full FIFO: write and dequeue in the same cycle is accepted
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, mkFlit((i == 0) ? HEAD_FLIT : BODY_FLIT, 1'b0, 8'(8'h41 + i)), 1'b1);
      tick();
    end
    checkOutput("t4 occ0 full", occ0, 4);
    applyStimulus(1'b1, mkFlit(TAIL_FLIT, 1'b0, 8'h45), 1'b0);
    checkOutput("t4 head", flit_out, mkFlit(HEAD_FLIT, 1'b0, 8'h41));
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("t4 occ0 held", occ0, 4);
    checkOutput("t4 no overflow", overflow_err, 0);
    checkOutput("t4 credit", credit_out, 2'b01);
    checkOutput("t4 flit 42", flit_out, mkFlit(BODY_FLIT, 1'b0, 8'h42));
    tick();
    checkOutput("t4 flit 43", flit_out, mkFlit(BODY_FLIT, 1'b0, 8'h43));
    checkOutput("t4 occ0 3", occ0, 3);
    tick();
    checkOutput("t4 flit 44", flit_out, mkFlit(BODY_FLIT, 1'b0, 8'h44));
    tick();
    checkOutput("t4 flit 45 wrapped", flit_out, mkFlit(TAIL_FLIT, 1'b0, 8'h45));
    tick();
    checkOutput("t4 drained valid", flit_valid_out, 0);
    checkOutput("t4 drained occ0", occ0, 0);
    checkOutput("t4 last credit", credit_out, 2'b01);

    // Lock holds on empty VC0 while VC1 has a SINGLE waiting
    applyStimulus(1'b1, mkFlit(HEAD_FLIT, 1'b0, 8'h51), 1'b0);
    tick();
    applyStimulus(1'b1, mkFlit(SINGLE_FLIT, 1'b1, 8'h61), 1'b0);
    checkOutput("t5 H0", flit_out, mkFlit(HEAD_FLIT, 1'b0, 8'h51));
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("t5 lock gap valid", flit_valid_out, 0);
    checkOutput("t5 occ1 waiting", occ1, 1);
    tick();
    checkOutput("t5 lock gap valid 2", flit_valid_out, 0);
    checkOutput("t5 no VC1 credit", credit_out, 0);
    applyStimulus(1'b1, mkFlit(BODY_FLIT, 1'b0, 8'h52), 1'b0);
    tick();
    applyStimulus(1'b1, mkFlit(TAIL_FLIT, 1'b0, 8'h53), 1'b0);
    checkOutput("t5 B0", flit_out, mkFlit(BODY_FLIT, 1'b0, 8'h52));
    checkOutput("t5 B0 valid", flit_valid_out, 1);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("t5 T0", flit_out, mkFlit(TAIL_FLIT, 1'b0, 8'h53));
    tick();
    checkOutput("t5 S1", flit_out, mkFlit(SINGLE_FLIT, 1'b1, 8'h61));
    checkOutput("t5 S1 valid", flit_valid_out, 1);
    tick();
    checkOutput("t5 S1 credit", credit_out, 2'b10);
    checkOutput("t5 occ1 end", occ1, 0);

    // Reset mid-packet with three buffered flits
    applyStimulus(1'b1, mkFlit(HEAD_FLIT, 1'b0, 8'h71), 1'b1);
    tick();
    applyStimulus(1'b1, mkFlit(BODY_FLIT, 1'b0, 8'h72), 1'b0);
    checkOutput("t6 H0", flit_out, mkFlit(HEAD_FLIT, 1'b0, 8'h71));
    tick();
    applyStimulus(1'b1, mkFlit(BODY_FLIT, 1'b0, 8'h73), 1'b1);
    checkOutput("t6 B72", flit_out, mkFlit(BODY_FLIT, 1'b0, 8'h72));
    tick();
    applyStimulus(1'b1, mkFlit(HEAD_FLIT, 1'b1, 8'h81), 1'b1);
    tick();
    checkOutput("t6 occ0 pre", occ0, 2);
    checkOutput("t6 occ1 pre", occ1, 1);
    applyStimulus(1'b0, '0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t6 occ0 flushed", occ0, 0);
    checkOutput("t6 occ1 flushed", occ1, 0);
    checkOutput("t6 valid flushed", flit_valid_out, 0);
    checkOutput("t6 credit flushed", credit_out, 0);
    applyStimulus(1'b1, mkFlit(BODY_FLIT, 1'b0, 8'h90), 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("t6 idle stray body hidden", flit_valid_out, 0);
    checkOutput("t6 stray body occ0", occ0, 1);
    tick();
    checkOutput("t6 stray body credit", credit_out, 2'b01);
    checkOutput("t6 stray body occ0 gone", occ0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule
